// File: rtl/sa_ram_pkg.sv
// Shared types and elaboration helpers for the parametrised 1R1W RAM model.
package sa_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Number of address bits needed to index 'value' words.
    function automatic int sa_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sa_ram_init_seq.sv
// Post-reset clear sequencer: walks every word once, then parks in RUN.
module sa_ram_init_seq
    import sa_ram_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int AW             = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rstn,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output logic          init_busy
);

    localparam ram_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

    ram_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clr_en    = (state_q == ST_INIT);
    assign clr_addr  = cnt_q;
    assign init_busy = clr_en;

endmodule

// File: rtl/sa_ram_rws_param.sv
// Parametrised 1R1W synchronous RAM with byte mask, 1/2-cycle read latency,
// defined collision behaviour and optional post-reset clear.
module sa_ram_rws_param
    import sa_ram_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int DW             = 512,
    parameter int AW             = 8,
    parameter int RD_LAT         = 1,
    parameter int WR_FIRST       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int MW            = DW / 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] ra,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [MW-1:0] wmask,
    input  logic [DW-1:0] di,
    output logic          init_busy,
    input  logic [31:0]   pwrbus_ram_pd
);

    localparam int          IW      = sa_clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    if (DW % 8 != 0) begin : g_bad_dw
        $error("sa_ram_rws_param: DW must be a multiple of 8");
    end
    if (AW < IW) begin : g_bad_aw
        $error("sa_ram_rws_param: AW too narrow for DEPTH");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("sa_ram_rws_param: RD_LAT must be 1 or 2");
    end

    logic          clr_en;
    logic [AW-1:0] clr_addr;

    sa_ram_init_seq #(
        .DEPTH          (DEPTH),
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init_seq (
        .clk       (clk),
        .rstn      (rstn),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    logic [DW-1:0] mem_q [DEPTH];

    logic          run, wa_ok, ra_ok, rd_fire;
    logic [DW-1:0] wr_old, wr_new, rd_word;
    logic          mem_we;
    logic [IW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    assign run     = !init_busy;
    assign wa_ok   = {1'b0, wa} < DEPTH_L;
    assign ra_ok   = {1'b0, ra} < DEPTH_L;
    assign rd_fire = run & re;
    assign wr_old  = mem_q[wa[IW-1:0]];

    always_comb begin
        wr_new = wr_old;
        for (int i = 0; i < MW; i++) begin
            if (wmask[i]) wr_new[8*i +: 8] = di[8*i +: 8];
        end
    end

    // Clearing owns the write port outright; user writes are ignored meanwhile.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa[IW-1:0];
        mem_wd = wr_new;
        if (clr_en) begin
            mem_we = 1'b1;
            mem_wa = clr_addr[IW-1:0];
            mem_wd = '0;
        end else if (run && we && wa_ok) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    always_comb begin
        rd_word = '0;
        if (ra_ok) begin
            if (WR_FIRST != 0 && run && we && wa_ok && ra == wa) rd_word = wr_new;
            else                                                  rd_word = mem_q[ra[IW-1:0]];
        end
    end

    // Each stage only loads when valid data arrives, so dout holds between reads.
    logic [RD_LAT-1:0][DW-1:0] rdat_q, rdat_d;
    logic [RD_LAT-1:0]         vld_pipe_q, vld_pipe_d;

    always_comb begin
        rdat_d        = rdat_q;
        vld_pipe_d    = '0;
        vld_pipe_d[0] = rd_fire;
        if (rd_fire) rdat_d[0] = rd_word;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            if (vld_pipe_q[k-1]) rdat_d[k] = rdat_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdat_q     <= '0;
            vld_pipe_q <= '0;
        end else begin
            rdat_q     <= rdat_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign dout     = rdat_q[RD_LAT-1];
    assign dout_vld = vld_pipe_q[RD_LAT-1];

    logic unused_pwr;
    assign unused_pwr = ^pwrbus_ram_pd;

endmodule
